// File: rtl/div_iter.sv
// Iterative restoring divider for div/divu: one quotient bit per cycle, stalls the
// pipeline while busy and presents {remainder, quotient} for one or more cycles in END.
//
// state  | meaning
// IDLE   | waiting for an accepted divide request
// BYZERO | divisor was zero; one-cycle detour before END
// ON     | one shift-subtract step per cycle, WIDTH steps
// END    | result valid; held until start_i drops
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic           neg_q;
  logic           neg_r;

  logic           accept;
  logic           op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_abs, op2_abs;
  logic [WIDTH:0] shifted;
  logic           ge;
  logic [WIDTH-1:0] rem_step, quot_step;
  logic           last;

  assign accept  = (state == S_IDLE) && start_i && !annul_i;
  assign op1_neg = signed_div_i && opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i && opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // rem < dvs always holds, so the WIDTH+1-bit shifted value minus dvs fits in WIDTH bits.
  assign shifted   = {rem, quot[WIDTH-1]};
  assign ge        = shifted >= {1'b0, dvs};
  assign rem_step  = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
  assign quot_step = {quot[WIDTH-2:0], ge};
  assign last      = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_nxt = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)   state_nxt = S_IDLE;
        else if (last) state_nxt = S_END;
      end
      S_END:    if (!start_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      quot  <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      neg_q <= op1_neg ^ op2_neg;
      neg_r <= op1_neg;
      if (opdata2_i == '0) begin
        // Divide-by-zero result is built here; the raw dividend is the remainder.
        quot <= '1;
        rem  <= opdata1_i;
        dvs  <= '0;
      end else begin
        quot <= op1_abs;
        rem  <= '0;
        dvs  <= op2_abs;
      end
    end else if (state == S_ON && !annul_i) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        quot <= neg_q ? (~quot_step + 1'b1) : quot_step;
        rem  <= neg_r ? (~rem_step + 1'b1) : rem_step;
      end else begin
        quot <= quot_step;
        rem  <= rem_step;
      end
    end
  end

  assign ready_o  = (state == S_END);
  assign result_o = (state == S_END) ? {rem, quot} : '0;
  // Gated by rst so the stall drops the instant reset asserts, even with start_i high.
  assign stallreq_o = rst && (accept || state == S_ON || state == S_BYZERO);

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, divide-by-zero,
// annul handling and asynchronous reset, with hand-computed expectations.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sdiv = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int checks = 0;
  int failures = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_div_i(sdiv),
    .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
    .result_o(result), .ready_o(ready), .stallreq_o(stall)
  );

  always #5 clk = ~clk;

  // Runs one divide holding start until ready, scrambling operands after acceptance.
  // Reports latency, result, stall-protocol violations and END-hold/release behaviour.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res,
                        output int stall_bad, output logic hold_ok);
    lat = -1; res = '0; stall_bad = 0; hold_ok = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sdiv = sg; op1 = a; op2 = b; annul = 1'b0;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      op1 = 32'hDEAD_BEEF; op2 = 32'h0; sdiv = ~sg;
      #1;
      if (ready === 1'b1) begin
        lat = c; res = result;
        if (stall !== 1'b0) stall_bad++;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
    end
    @(posedge clk); #1;
    hold_ok = (ready === 1'b1) && (result === res);
    start = 1'b0;
    @(posedge clk); #1;
    hold_ok = hold_ok && (ready === 1'b0) && (result === 64'h0);
  endtask

  task automatic test_reset;
    start = 1'b1; op1 = 32'd100; op2 = 32'd7;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'h0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b result=%h stall=%b, required 0/0/0", ready, result, stall);
    end
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic test_divu_basic;
    int lat, sb; logic [63:0] res; logic hok;
    do_div(1'b0, 32'd100, 32'd7, lat, res, sb, hok);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL divu_latency: got %0d, required 33", lat); end
    checks++;
    if (res !== {32'h2, 32'hE}) begin failures++; $display("FAIL divu_100_7: got %h, required %h", res, {32'h2, 32'hE}); end
    checks++;
    if (sb !== 0) begin failures++; $display("FAIL divu_stallreq: %0d bad cycles, required 0", sb); end
    checks++;
    if (hok !== 1'b1) begin failures++; $display("FAIL end_hold_release: got %b, required 1", hok); end
  endtask

  task automatic test_results;
    logic        sg[6];
    logic [31:0] a[6], b[6], eq[6], er[6];
    int lat, sb; logic [63:0] res; logic hok;
    sg[0]=1; a[0]=32'hFFFFFFF9; b[0]=32'd2;        eq[0]=32'hFFFFFFFD; er[0]=32'hFFFFFFFF;
    sg[1]=1; a[1]=32'd7;        b[1]=32'hFFFFFFFE; eq[1]=32'hFFFFFFFD; er[1]=32'h1;
    sg[2]=1; a[2]=32'h80000000; b[2]=32'hFFFFFFFF; eq[2]=32'h80000000; er[2]=32'h0;
    sg[3]=0; a[3]=32'hFFFFFFFF; b[3]=32'd1;        eq[3]=32'hFFFFFFFF; er[3]=32'h0;
    sg[4]=0; a[4]=32'hFFFFFFF9; b[4]=32'd2;        eq[4]=32'h7FFFFFFC; er[4]=32'h1;
    sg[5]=1; a[5]=32'hFFFFFF9C; b[5]=32'hFFFFFFF9; eq[5]=32'd14;       er[5]=32'hFFFFFFFE;
    for (int i = 0; i < 6; i++) begin
      do_div(sg[i], a[i], b[i], lat, res, sb, hok);
      checks++;
      if (res !== {er[i], eq[i]} || lat !== 33) begin
        failures++;
        $display("FAIL div_vec%0d: got %h lat %0d, required %h lat 33", i, res, lat, {er[i], eq[i]});
      end
    end
  endtask

  task automatic test_byzero;
    int lat, sb; logic [63:0] res; logic hok;
    do_div(1'b0, 32'd5, 32'd0, lat, res, sb, hok);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL byzero_latency: got %0d, required 2", lat); end
    checks++;
    if (res !== {32'h5, 32'hFFFFFFFF}) begin failures++; $display("FAIL byzero_divu: got %h, required %h", res, {32'h5, 32'hFFFFFFFF}); end
    checks++;
    if (sb !== 0) begin failures++; $display("FAIL byzero_stallreq: %0d bad cycles, required 0", sb); end
    do_div(1'b1, 32'hFFFFFFFB, 32'd0, lat, res, sb, hok);
    checks++;
    if (res !== {32'hFFFFFFFB, 32'hFFFFFFFF} || lat !== 2) begin
      failures++; $display("FAIL byzero_div: got %h lat %0d, required %h lat 2", res, lat, {32'hFFFFFFFB, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_annul;
    int bad = 0; int lat, sb; logic [63:0] res; logic hok;
    @(posedge clk); #1;
    start = 1'b1; sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) bad++;
      if (c == 10) annul = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    #1;
    checks++;
    if (bad != 0 || ready !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL annul_on: ready_hits=%0d ready=%b stall=%b, required 0/0/0", bad, ready, stall);
    end
    do_div(1'b0, 32'd9, 32'd3, lat, res, sb, hok);
    checks++;
    if (res !== {32'h0, 32'h3} || lat !== 33) begin
      failures++; $display("FAIL after_annul_9_3: got %h lat %0d, required %h lat 33", res, lat, {32'h0, 32'h3});
    end
  endtask

  task automatic test_annul_last;
    int bad = 0;
    @(posedge clk); #1;
    start = 1'b1; sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) bad++;
      if (c == 32) annul = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    #1;
    checks++;
    if (bad != 0 || ready !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL annul_last_step: ready_hits=%0d ready=%b stall=%b, required 0/0/0", bad, ready, stall);
    end
  endtask

  task automatic test_annul_idle;
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL annul_idle_stall: got %b, required 0", stall); end
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; annul = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL annul_idle_block: stall=%b ready=%b, required 0/0", stall, ready);
    end
  endtask

  task automatic test_async_reset;
    int lat, sb; logic [63:0] res; logic hok;
    @(posedge clk); #1;
    start = 1'b1; sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'h0 || stall !== 1'b0) begin
      failures++; $display("FAIL async_reset: ready=%b result=%h stall=%b, required 0/0/0", ready, result, stall);
    end
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    do_div(1'b0, 32'd100, 32'd7, lat, res, sb, hok);
    checks++;
    if (res !== {32'h2, 32'hE} || lat !== 33) begin
      failures++; $display("FAIL after_reset_100_7: got %h lat %0d, required %h lat 33", res, lat, {32'h2, 32'hE});
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_results;
    test_byzero;
    test_annul;
    test_annul_last;
    test_annul_idle;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
